tetris_piece_queue: RTL and testbench
=====================================

TETRIS_PIECE_QUEUE -- requirements
Module: tetris_piece_queue

Interface
REQ-001 Parameter LFSR_W, default 16, SHALL set the LFSR state width; legal range 8..32.
REQ-002 Parameter LFSR_TAPS, default 16'hB400, SHALL set the Galois feedback mask and is LFSR_W bits wide.
REQ-003 Parameter DEPTH, default 4, SHALL set the preview queue depth; legal range 1..8.
REQ-004 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-006 seed  in  LFSR_W  SHALL be the LFSR start value, sampled on reset and on seed_load.
REQ-007 seed_load  in  1  SHALL request a reseed and flush.
REQ-008 pop  in  1  SHALL consume the head piece.
REQ-009 piece  out  3  SHALL carry the head piece index, 0..6; 3'd7 when empty.
REQ-010 piece_valid  out  1  SHALL be high when count > 0.
REQ-011 preview  out  3*DEPTH  SHALL carry the queue slots; slot k is at bits [3k+2:3k], slot 0 is the head, and empty slots read 3'd7.
REQ-012 count  out  $clog2(DEPTH+1)  SHALL carry the number of valid slots.

Function
REQ-013 LFSR next state SHALL be (lfsr >> 1) XOR (lfsr[0] ? LFSR_TAPS : 0).
REQ-014 Each cycle with count < DEPTH, or with count == DEPTH and pop accepted, the LFSR SHALL advance one step.
- Candidate = current lfsr[2:0], taken before the advance.
REQ-015 A candidate of 7 SHALL be rejected (no push), giving uniform 0..6 with no modulo bias; the LFSR still advances.
REQ-016 An accepted candidate SHALL be written to slot count, or to slot count-1 when a pop occurs in the same cycle.
REQ-017 pop with piece_valid high SHALL shift the slots down one position.
- Vacated top slot reads 7.
- count decrements unless a push occurs in the same cycle.
REQ-018 pop with piece_valid low SHALL be ignored with no state change.
REQ-019 With count == DEPTH and no pop, the LFSR and the queue SHALL hold.
REQ-020 A simultaneous pop and push SHALL leave count unchanged.
REQ-021 seed_load SHALL, in one cycle, load the LFSR from seed, set count to 0, set all slots to 7, and clear bag state.
- Any pop or push in that cycle is discarded.
REQ-022 Priority SHALL be rst > seed_load > pop/push.
REQ-023 A seed value of zero SHALL be replaced by all-ones to avoid LFSR lockup, on both reset and seed_load.
REQ-024 The first candidate SHALL be evaluated in the first cycle after rst or seed_load deasserts.
- piece_valid rises at the earliest one cycle later.
REQ-025 Outputs SHALL be registered; no combinational path from pop to any output.

Reset
REQ-026 On rst high at a clock edge, the block SHALL set:
- lfsr = seed (or all-ones if seed is zero)
- count = 0, all slots = 7
- bag mask = 0
REQ-027 While rst is high, outputs SHALL read piece = 7, piece_valid = 0, count = 0, preview all 7s.

Configuration
REQ-028 Macro TETRIS_PIECE_BAG_EN, when defined, SHALL enable 7-bag mode.
- A 7-bit used-mask rejects any candidate whose bit is already set.
- Accepting the 7th distinct piece clears the mask in that same cycle.
- Every aligned group of 7 consecutive pushes is then a permutation of 0..6.
REQ-029 Without TETRIS_PIECE_BAG_EN, the SHALL NOT be any mask logic; only value 7 is rejected.

Verification
REQ-030 Defaults, seed 16'h0001, rst for 2 cycles then released, no pop -> pushes 1, 0, 0, 0 (LFSR 0001, B400, 5A00, 2D00); count reaches 4 after 4 cycles, then holds.
REQ-031 seed 16'h0007, reset released -> candidate 7 rejected in cycle 1; LFSR becomes B403; piece = 3 with piece_valid high two cycles after release.
REQ-032 Full queue, pop held for 10 cycles -> count stays 4; piece advances every cycle; no value 7 appears while valid.
REQ-033 seed 0, reset -> LFSR = all-ones (FFFF); first candidate 7 rejected; no lockup.
REQ-034 Mid-fill, pop and seed_load asserted together -> next cycle count = 0, preview all 7s, LFSR = new seed.
REQ-035 TETRIS_PIECE_BAG_EN defined, seed 16'h0001, 700 pops -> each group of 7 consecutive pushes is a permutation of 0..6; after the leading 1, the repeated candidates 0, 0 are rejected.

Source files
------------

// File: rtl/tetris_piece_queue.sv
// Tetris piece preview queue.
// A Galois LFSR supplies 3-bit candidates; value 7 is rejected so accepted
// pieces are uniform over 0..6. Accepted pieces fill a DEPTH-slot preview
// queue whose head is consumed by pop.
// Optional feature: define TETRIS_PIECE_BAG_EN for 7-bag mode. In this mode
// every aligned run of 7 pushes is a permutation of 0..6.
module tetris_piece_queue #(
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(16'hB400),
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LFSR_W-1:0]    seed,
  input  logic                 seed_load,
  input  logic                 pop,
  output logic [2:0]           piece,
  output logic                 piece_valid,
  output logic [3*DEPTH-1:0]   preview,
  output logic [CW-1:0]        count
);

  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_next;
  logic [LFSR_W-1:0] seed_eff;
  logic [2:0]        slots   [DEPTH];
  logic [2:0]        slots_n [DEPTH];
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_n;
  logic [CW-1:0]     wr_idx;
  logic [2:0]        cand;
  logic              pop_ok;
  logic              advance;
  logic              cand_ok;
  logic              accept;

`ifdef TETRIS_PIECE_BAG_EN
  logic [6:0] bag;
  logic [6:0] bag_n;
  logic [6:0] cand_bit;
  logic [6:0] bag_set;
`endif

  // An all-zero seed would lock the LFSR, so it is replaced by all-ones
  assign seed_eff = (seed == '0) ? '1 : seed;
  assign cand     = lfsr[2:0];

  // Decide whether the generator steps this cycle and whether its candidate is kept
  always_comb begin
    lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
    pop_ok    = pop && (cnt != '0);
    advance   = (cnt < CW'(DEPTH)) || pop_ok;
`ifdef TETRIS_PIECE_BAG_EN
    cand_bit  = 7'(1) << cand;
    cand_ok   = (cand != 3'd7) && ((bag & cand_bit) == '0);
    bag_set   = bag | cand_bit;
`else
    cand_ok   = (cand != 3'd7);
`endif
    accept    = advance && cand_ok;
    wr_idx    = pop_ok ? (cnt - CW'(1)) : cnt;
  end

  // Next queue contents: shift on pop, then drop the accepted piece into the first free slot
  always_comb begin
    for (int i = 0; i < DEPTH; i++) slots_n[i] = slots[i];
    if (pop_ok) begin
      for (int i = 0; i < DEPTH - 1; i++) slots_n[i] = slots[i + 1];
      slots_n[DEPTH-1] = 3'd7;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && (CW'(i) == wr_idx)) slots_n[i] = cand;
    end
    cnt_n = cnt;
    if (accept && !pop_ok) cnt_n = cnt + CW'(1);
    else if (!accept && pop_ok) cnt_n = cnt - CW'(1);
  end

`ifdef TETRIS_PIECE_BAG_EN
  // The bag empties in the same cycle its seventh distinct piece is taken
  always_comb begin
    bag_n = bag;
    if (accept) bag_n = (bag_set == 7'h7F) ? '0 : bag_set;
  end
`endif

  // State update; reset and reseed both restart the generator and flush the queue
  always_ff @(posedge clk) begin
    if (rst || seed_load) begin
      lfsr <= seed_eff;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) slots[i] <= 3'd7;
`ifdef TETRIS_PIECE_BAG_EN
      bag  <= '0;
`endif
    end else begin
      if (advance) lfsr <= lfsr_next;
      cnt <= cnt_n;
      for (int i = 0; i < DEPTH; i++) slots[i] <= slots_n[i];
`ifdef TETRIS_PIECE_BAG_EN
      bag <= bag_n;
`endif
    end
  end

  // Outputs come straight from state registers, so pop never reaches them combinationally
  always_comb begin
    for (int i = 0; i < DEPTH; i++) preview[3*i +: 3] = slots[i];
    piece       = slots[0];
    piece_valid = (cnt != '0);
    count       = cnt;
  end

endmodule

// File: tb/tb_tetris_piece_queue.sv
// Self-checking bench for tetris_piece_queue: directed scenarios plus a
// randomized run, compared against a queue-based reference model.
module tb_tetris_piece_queue;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] TAPS = 16'hB400;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [LFSR_W-1:0]   seed = '0;
  logic                seed_load = 1'b0;
  logic                pop = 1'b0;
  logic [2:0]          piece;
  logic                piece_valid;
  logic [3*DEPTH-1:0]  preview;
  logic [CW-1:0]       count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [LFSR_W-1:0] mLfsr;
  int                q[$];
  logic [6:0]        used;

  int  popLog[$];
  bit  logOn = 1'b0;

  tetris_piece_queue #(.LFSR_W(LFSR_W), .LFSR_TAPS(TAPS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .seed(seed), .seed_load(seed_load), .pop(pop),
    .piece(piece), .piece_valid(piece_valid), .preview(preview), .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void modelStep(input logic r, input logic sl, input logic p,
                                    input logic [LFSR_W-1:0] s);
    int  c;
    bit  popOk;
    bit  keep;
    if (r || sl) begin
      mLfsr = (s == 0) ? '1 : s;
      q.delete();
      used = '0;
    end else begin
      popOk = p && (q.size() > 0);
      if (q.size() < DEPTH || popOk) begin
        if (popOk) void'(q.pop_front());
        c = int'(mLfsr % 8);
        keep = (c != 7);
`ifdef TETRIS_PIECE_BAG_EN
        if (keep && used[c]) keep = 1'b0;
`endif
        if (keep) begin
          q.push_back(c);
`ifdef TETRIS_PIECE_BAG_EN
          used[c] = 1'b1;
          if (used == 7'h7F) used = '0;
`endif
        end
        mLfsr = (mLfsr >> 1) ^ (mLfsr[0] ? TAPS : '0);
      end
    end
  endfunction

  task automatic compareAll();
    logic [3*DEPTH-1:0] expPrev;
    for (int k = 0; k < DEPTH; k++)
      expPrev[3*k +: 3] = (k < q.size()) ? 3'(q[k]) : 3'd7;
    checkOutput("piece", 32'(piece), (q.size() > 0) ? 32'(q[0]) : 32'd7);
    checkOutput("valid", 32'(piece_valid), 32'(q.size() > 0));
    checkOutput("count", 32'(count), 32'(q.size()));
    checkOutput("preview", 32'(preview), 32'(expPrev));
  endtask

  task automatic applyStimulus(input logic r, input logic sl, input logic p,
                               input logic [LFSR_W-1:0] s);
    rst = r; seed_load = sl; pop = p; seed = s;
    if (logOn && p && piece_valid && !r && !sl) popLog.push_back(int'(piece));
    @(posedge clk);
    modelStep(r, sl, p, s);
    #1;
    compareAll();
  endtask

  initial begin
    logic [LFSR_W-1:0] rs;
    logic [6:0]        seen;

    // Seed 1: pushes 1,0,0,0 then the full queue holds
    applyStimulus(1, 0, 0, 16'h0001);
    applyStimulus(1, 0, 0, 16'h0001);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_preview", 32'(preview), 32'hFFF);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 0, 0, 16'h0001);
`ifndef TETRIS_PIECE_BAG_EN
      checkOutput("fill_count", 32'(count), (i < 4) ? 32'(i + 1) : 32'd4);
`endif
    end
`ifndef TETRIS_PIECE_BAG_EN
    checkOutput("fill_preview", 32'(preview), 32'h001);
`endif

    // Full queue with pop held: count stays full, head never shows 7
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 1, 16'h0001);
      checkOutput("pop_no7", 32'(piece_valid && piece == 3'd7), 32'd0);
    end

    // Seed 7: first candidate rejected, piece 3 appears two cycles after release
    applyStimulus(1, 0, 0, 16'h0007);
    applyStimulus(0, 0, 0, 16'h0007);
    checkOutput("s7_cyc1_count", 32'(count), 32'd0);
    applyStimulus(0, 0, 0, 16'h0007);
    checkOutput("s7_piece", 32'(piece), 32'd3);
    checkOutput("s7_valid", 32'(piece_valid), 32'd1);

    // Seed 0 behaves as all-ones: first candidate 7 is rejected
    applyStimulus(1, 0, 0, 16'h0000);
    applyStimulus(0, 0, 0, 16'h0000);
    checkOutput("s0_count", 32'(count), 32'd0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 16'h0000);
    checkOutput("s0_nolock", 32'(count), 32'd4);

    // Reseed mid-fill with a pop in the same cycle: queue flushes, new seed drives next push
    applyStimulus(1, 0, 0, 16'h0001);
    applyStimulus(0, 0, 0, 16'h0001);
    applyStimulus(0, 0, 0, 16'h0001);
    applyStimulus(0, 1, 1, 16'h1234);
    checkOutput("reseed_count", 32'(count), 32'd0);
    checkOutput("reseed_preview", 32'(preview), 32'hFFF);
    applyStimulus(0, 0, 0, 16'h1234);
    checkOutput("reseed_piece", 32'(piece), 32'd4);

    // Pop with an empty queue is ignored
    applyStimulus(0, 1, 0, 16'h0007);
    applyStimulus(0, 0, 1, 16'h0007);
    checkOutput("empty_pop_count", 32'(count), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      rs = LFSR_W'($urandom);
      if ($urandom_range(0, 9) == 0) rs = '0;
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 99) < 60), rs);
    end

    // Long pop run from seed 1; in bag mode every group of 7 popped pieces is a permutation
    applyStimulus(1, 0, 0, 16'h0001);
    logOn = 1'b1;
    for (int i = 0; i < 700; i++) applyStimulus(0, 0, 1, 16'h0001);
    logOn = 1'b0;
`ifdef TETRIS_PIECE_BAG_EN
    for (int g = 0; g + 7 <= popLog.size(); g += 7) begin
      seen = '0;
      for (int j = 0; j < 7; j++)
        if (popLog[g+j] < 7) seen[popLog[g+j]] = 1'b1;
      checkOutput("bag_perm", 32'(seen), 32'h7F);
    end
`else
    checkOutput("pop_log_size", 32'(popLog.size() > 0), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
